// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: state encoding and
// the default operand width.
package serial_add_ctrl_pkg;

    localparam int WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_add_ctrl_fa_cell.sv
// One-bit full adder built from two cascaded half adders; the two half-adder
// carries can never both be set, so an OR merges them.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);

    logic ha1_sum_s;
    logic ha1_carry_s;
    logic ha2_carry_s;

    assign ha1_sum_s   = a ^ b;
    assign ha1_carry_s = a & b;
    assign sum         = ha1_sum_s ^ cin;
    assign ha2_carry_s = ha1_sum_s & cin;
    assign carry       = ha1_carry_s | ha2_carry_s;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: operands are shifted LSB-first through a single full-adder
// cell, one bit per clock, with the result assembled by right-shifting sum.
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state_r;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic             carry_r;
    logic [CW-1:0]    cnt_r;
    logic             fa_sum_s;
    logic             fa_carry_s;

    fa_cell u_fa (
        .a     (a_sh_r[0]),
        .b     (b_sh_r[0]),
        .cin   (carry_r),
        .sum   (fa_sum_s),
        .carry (fa_carry_s)
    );

    // Controller FSM with datapath registers and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            a_sh_r  <= {WIDTH{1'b0}};
            b_sh_r  <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            cnt_r   <= {CW{1'b0}};
            sum     <= {WIDTH{1'b0}};
            cout    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh_r  <= a;
                        b_sh_r  <= b;
                        carry_r <= cin;
                        cnt_r   <= {CW{1'b0}};
                        sum     <= {WIDTH{1'b0}};
                        cout    <= 1'b0;
                        busy    <= 1'b1;
                        state_r <= RUN;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    a_sh_r  <= {1'b0, a_sh_r[WIDTH-1:1]};
                    b_sh_r  <= {1'b0, b_sh_r[WIDTH-1:1]};
                    carry_r <= fa_carry_s;
                    sum     <= {fa_sum_s, sum[WIDTH-1:1]};
                    // The counter parks on the last bit so it never wraps.
                    if (cnt_r == LAST_BIT) begin
                        cout    <= fa_carry_s;
                        done    <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        cnt_r   <= cnt_r + CW'(1);
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: stimulus pushes expected a+b+cin and
// acceptance edge; a monitor checks results, done timing and busy.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    typedef struct {
        logic [W:0] exp;
        int         t0;
    } op_t;

    op_t  q[$];
    int   edge_cnt = 0;
    int   last_t0  = -1000;
    int   accepted = 0;
    int   errors   = 0;
    int   checks   = 0;
    logic mon_en   = 1'b0;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, req, edge_cnt);
        end
    endtask

    // One cycle of stimulus; the model accepts a start only when the previous
    // operation left at least W+2 edges between acceptances.
    task automatic drive(input logic s, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic cv);
        op_t op;
        @(negedge clk);
        #1;
        start = s;
        a     = av;
        b     = bv;
        cin   = cv;
        if (s && (edge_cnt + 1 >= last_t0 + W + 2)) begin
            op.exp = (W+1)'(av) + (W+1)'(bv) + (W+1)'(cv);
            op.t0  = edge_cnt + 1;
            q.push_back(op);
            last_t0 = edge_cnt + 1;
            accepted++;
        end
    endtask

    task automatic idle_noise(input int n);
        for (int i = 0; i < n; i++)
            drive(1'b0, W'($urandom), W'($urandom), 1'($urandom));
    endtask

    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
        drive(1'b1, av, bv, cv);
        idle_noise(W + 1);
    endtask

    // Monitor: pops the scoreboard on each done pulse and tracks busy.
    initial begin
        op_t op;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                check("busy", 64'(busy),
                      64'((edge_cnt >= last_t0) && (edge_cnt <= last_t0 + W)));
                if (edge_cnt == last_t0)
                    check("sum_clear", {55'd0, cout, sum}, 64'd0);
                if (done) begin
                    if (q.size() == 0) begin
                        check("unexpected_done", 64'(done), 64'd0);
                    end else begin
                        op = q.pop_front();
                        check("done_time", 64'(edge_cnt), 64'(op.t0 + W));
                        check("result", {55'd0, cout, sum}, {55'd0, op.exp});
                    end
                end else if (q.size() > 0 && q[0].t0 + W <= edge_cnt) begin
                    op = q.pop_front();
                    check("missing_done", 64'(done), 64'd1);
                end
            end
        end
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        #12;
        check("reset_outputs", {52'd0, busy, done, cout, sum}, 64'd0);
        @(negedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        do_op(8'h0F, 8'h01, 1'b0);
        do_op(8'hFF, 8'h01, 1'b0);
        do_op(8'h00, 8'h00, 1'b1);
        do_op(8'hFF, 8'hFF, 1'b1);

        // Start re-pulsed with new operands during RUN must be ignored.
        drive(1'b1, 8'h0F, 8'h01, 1'b0);
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        drive(1'b1, 8'hAA, 8'h55, 1'b1);
        idle_noise(W);

        // Reset mid-operation aborts it and clears outputs asynchronously.
        drive(1'b1, 8'h7E, 8'h3C, 1'b1);
        idle_noise(3);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_outputs", {52'd0, busy, done, cout, sum}, 64'd0);
        q.delete();
        last_t0 = -1000;
        @(negedge clk);
        #1;
        rst = 1'b0;
        do_op(8'h12, 8'h34, 1'b1);

        while (accepted < 506)
            drive(($urandom_range(0, 3) == 0), W'($urandom), W'($urandom), 1'($urandom));
        idle_noise(W + 3);
        check("scoreboard_empty", 64'(q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
